// File: rtl/apb_to_ahb_bridge_if.sv
// Bus bundle for apb_to_ahb_bridge: the APB slave-side signals and the
// AHB-Lite master-side signals, both clocked by HCLK.
//   slave  : the bridge's view (receives APB, drives AHB)
//   master : the environment's view (drives APB, answers AHB)
interface apb_to_ahb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // APB side
    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    // AHB-Lite side
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic [1:0]            HRESP;

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  HRDATA, HREADY, HRESP,
        output PRDATA, PREADY, PSLVERR,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output HRDATA, HREADY, HRESP,
        input  PRDATA, PREADY, PSLVERR,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
endinterface

// File: rtl/apb_to_ahb_bridge.sv
// apb_to_ahb_bridge: APB slave port that turns each APB transfer into one
// AHB-Lite SINGLE transfer. PREADY stays low until the AHB data phase has
// completed; the completion is presented for exactly one cycle.
//
// Optional feature macro: APB_TO_AHB_BRIDGE_PSLVERR_EN
//   defined   : an AHB ERROR response is reported on PSLVERR
//   undefined : PSLVERR is tied low, an ERROR response completes normally
//
// Every output is decoded from registers only, so nothing on the AHB or APB
// inputs can ripple combinationally to an output.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an APB setup phase (PSEL=1, PENABLE=0)
// ADDR  | AHB address phase, HTRANS=NONSEQ, held while HREADY=0
// DATA  | AHB data phase, HTRANS=IDLE, waits for HREADY=1
// DONE  | PREADY=1 for one cycle with PRDATA/PSLVERR, then IDLE
module apb_to_ahb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    apb_to_ahb_bridge_if.slave      bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BUS     = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  capture_setup;
    logic                  data_done;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // State register; an asynchronous reset abandons any transfer in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the two capture strobes used by the datapath.
    always_comb begin
        state_d       = state_q;
        capture_setup = 1'b0;
        data_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    capture_setup = 1'b1;
                    state_d       = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // APB select is deliberately ignored from here on: once the
                // address phase is issued the AHB transfer must finish.
                if (bus.HREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.HREADY) begin
                    data_done = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                // A setup phase seen here is not taken; a compliant master
                // cannot present one while its access is still completing.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the APB request at the setup phase; held for the whole transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (capture_setup) begin
            addr_q  <= bus.PADDR;
            write_q <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
        end
    end

    // Capture read data when the AHB data phase completes; writes leave the
    // previous read value in place so PRDATA keeps showing it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rdata_q <= '0;
        end else if (data_done && !write_q) begin
            rdata_q <= bus.HRDATA;
        end
    end

`ifdef APB_TO_AHB_BRIDGE_PSLVERR_EN
    logic err_q;

    // Record whether the completing data phase carried an ERROR response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_q <= 1'b0;
        end else if (data_done) begin
            err_q <= (bus.HRESP == 2'b01);
        end
    end

    // Error flag is only meaningful alongside PREADY.
    always_comb begin
        bus.PSLVERR = (state_q == ST_DONE) && err_q;
    end
`else
    // Without error reporting HRESP has no effect on the transfer.
    logic unused_hresp;
    assign unused_hresp = ^bus.HRESP;

    // Error flag permanently low.
    always_comb begin
        bus.PSLVERR = 1'b0;
    end
`endif

    // AHB address/control: NONSEQ only during the address phase.
    always_comb begin
        bus.HTRANS = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        bus.HADDR  = addr_q;
        bus.HWRITE = write_q;
        bus.HSIZE  = HSIZE_BUS;
        bus.HBURST = HBURST_SINGLE;
        bus.HWDATA = wdata_q;
    end

    // APB completion: one-cycle PREADY, PRDATA always shows the last read.
    always_comb begin
        bus.PREADY = (state_q == ST_DONE);
        bus.PRDATA = rdata_q;
    end

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// Self-checking bench for apb_to_ahb_bridge. The bench plays both the APB
// master and the AHB slave, choosing wait states and responses itself, and
// predicts completion cycle, PRDATA and PSLVERR from the transfer rules.
module tb_apb_to_ahb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;

    logic HCLK = 1'b0;
    logic HRESETn;

    always #5 HCLK = ~HCLK;

    apb_to_ahb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_to_ahb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference state: PRDATA shows the most recent completed read (0 after reset).
    logic [DW-1:0] model_prdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One APB transfer. aw/dw: AHB wait cycles in the address/data phase.
    // err: two-cycle ERROR response (needs dw >= 1). drop: master drops PSEL
    // after setup. Completion is expected 3+aw+dw cycles after the setup cycle.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                        input int aw, input int dw, input logic err,
                        input logic [DW-1:0] rdata, input logic drop);
        logic exp_err;
`ifdef APB_TO_AHB_BRIDGE_PSLVERR_EN
        exp_err = err;
`else
        exp_err = 1'b0;
`endif
        @(negedge HCLK);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PADDR   = addr;
        bus.PWRITE  = wr;
        bus.PWDATA  = wdata;
        bus.HREADY  = (aw == 0);
        bus.HRESP   = 2'b00;
        for (int k = 1; k <= aw + 1; k++) begin
            @(negedge HCLK);
            if (k == 1) begin
                if (drop) begin
                    bus.PSEL    = 1'b0;
                    bus.PENABLE = 1'b0;
                end else begin
                    bus.PENABLE = 1'b1;
                end
            end
            chk("addr_htrans", bus.HTRANS, 64'h2);
            chk("addr_haddr", bus.HADDR, addr);
            chk("addr_hwrite", bus.HWRITE, wr);
            chk("addr_pready", bus.PREADY, 0);
            bus.HREADY = (k == aw + 1);
        end
        for (int k = 1; k <= dw + 1; k++) begin
            @(negedge HCLK);
            chk("data_htrans", bus.HTRANS, 0);
            chk("data_pready", bus.PREADY, 0);
            if (wr) chk("data_hwdata", bus.HWDATA, wdata);
            bus.HREADY = (k == dw + 1);
            bus.HRESP  = (err && k >= dw) ? 2'b01 : 2'b00;
            bus.HRDATA = (k == dw + 1) ? rdata : DW'($urandom);
        end
        @(negedge HCLK);
        if (!wr) model_prdata = rdata;
        chk("done_pready", bus.PREADY, 1);
        chk("done_pslverr", bus.PSLVERR, exp_err);
        chk("done_prdata", bus.PRDATA, model_prdata);
        chk("done_htrans", bus.HTRANS, 0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.HREADY  = 1'b1;
        bus.HRESP   = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int aw;
        int dw;
        logic err;
        logic wr;

        HRESETn     = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PADDR   = '0;
        bus.PWRITE  = 1'b0;
        bus.PWDATA  = '0;
        bus.HRDATA  = '0;
        bus.HREADY  = 1'b1;
        bus.HRESP   = 2'b00;
        model_prdata = '0;

        // Reset values
        repeat (2) @(negedge HCLK);
        chk("rst_pready", bus.PREADY, 0);
        chk("rst_pslverr", bus.PSLVERR, 0);
        chk("rst_htrans", bus.HTRANS, 0);
        chk("rst_prdata", bus.PRDATA, 0);
        chk("rst_haddr", bus.HADDR, 0);
        chk("rst_hwrite", bus.HWRITE, 0);
        chk("rst_hwdata", bus.HWDATA, 0);
        chk("hsize", bus.HSIZE, $clog2(DW / 8));
        chk("hburst", bus.HBURST, 0);
        HRESETn = 1'b1;

        // Idle with PSEL low: no AHB activity
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            chk("idle_htrans", bus.HTRANS, 0);
            chk("idle_pready", bus.PREADY, 0);
        end

        // Directed transfers
        xfer(32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, 1'b0);
        xfer(32'h0000_2004, 1'b0, 32'h0, 0, 2, 1'b0, 32'h1234_5678, 1'b0);
        xfer(32'h0000_2008, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0BAD_0BAD, 1'b0);
        xfer(32'h0000_3000, 1'b1, 32'h5555_AAAA, 3, 0, 1'b0, 32'h0, 1'b0);
        xfer(32'h0000_300C, 1'b1, 32'h0F0F_0F0F, 1, 1, 1'b1, 32'h0, 1'b0);
        xfer(32'h0000_4000, 1'b0, 32'h0, 1, 0, 1'b0, 32'h7777_1111, 1'b1);

        // Randomized back-to-back transfers
        for (int i = 0; i < 24; i++) begin
            aw  = $urandom_range(0, 2);
            dw  = $urandom_range(0, 2);
            err = ($urandom_range(0, 3) == 0);
            wr  = $urandom_range(0, 1) == 1;
            if (err && dw == 0) dw = 1;
            xfer({$urandom} & 32'hFFFF_FFFC, wr, DW'($urandom), aw, dw, err,
                 DW'($urandom), $urandom_range(0, 7) == 0);
        end

        // Reset asserted during the data phase
        @(negedge HCLK);
        bus.PSEL   = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PADDR  = 32'h0000_5000;
        bus.PWRITE = 1'b1;
        bus.PWDATA = 32'hCAFE_F00D;
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        bus.PENABLE = 1'b1;
        chk("rstx_addr_htrans", bus.HTRANS, 64'h2);
        @(negedge HCLK);
        chk("rstx_data_hwdata", bus.HWDATA, 32'hCAFE_F00D);
        bus.HREADY = 1'b0;
        @(posedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        model_prdata = '0;
        chk("rstx_htrans", bus.HTRANS, 0);
        chk("rstx_pready", bus.PREADY, 0);
        chk("rstx_hwdata", bus.HWDATA, 0);
        chk("rstx_haddr", bus.HADDR, 0);
        chk("rstx_prdata", bus.PRDATA, model_prdata);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        repeat (2) @(negedge HCLK);
        HRESETn    = 1'b1;
        bus.HREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            chk("post_rst_pready", bus.PREADY, 0);
            chk("post_rst_htrans", bus.HTRANS, 0);
        end
        xfer(32'h0000_6000, 1'b1, 32'hA5A5_A5A5, 0, 0, 1'b0, 32'h0, 1'b0);
        xfer(32'h0000_6004, 1'b0, 32'h0, 0, 0, 1'b0, 32'h3C3C_C3C3, 1'b0);

        @(negedge HCLK);
        chk("final_pready", bus.PREADY, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
